// File: rtl/gb_mem_pkg.sv
// gb_mem_pkg
//  Shared constants for the Game Boy memory bus arbiter slice:
//  arbiter FSM state encodings, requester port ids and the default
//  memory read latency.
package gb_mem_pkg;

  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_ACCESS = 2'd1;
  localparam logic [1:0] ARB_RESP   = 2'd2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam int DEFAULT_READ_LATENCY = 1;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
//  Combinational winner select for the memory bus arbiter.
//  Ports:
//    req0, req1  in   pending requests from cpu (0) and DMA (1)
//    last_port   in   port that received the most recent grant
//    valid       out  at least one request pending
//    port        out  winning port id
//  Configuration macro: MEM_ARB_ROUND_ROBIN_EN
//    defined   -> on a tie, grant the port that did not win last time
//    undefined -> fixed priority, DMA always beats cpu
module mem_arb_pick
  import gb_mem_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_port,
  output logic valid,
  output logic port
);

  assign valid = req0 | req1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    port = PORT_CPU;
    if (req0 && req1) begin
      port = ~last_port;
    end else if (req1) begin
      port = PORT_DMA;
    end
  end
`else
  // History is irrelevant under fixed priority.
  logic unused_last_port;
  assign unused_last_port = last_port;

  assign port = req1 ? PORT_DMA : PORT_CPU;
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//  Shares the single-port memory bus between the cpu (port 0) and the
//  DMA engine (port 1). Each access runs IDLE -> ACCESS -> RESP, lasting
//  READ_LATENCY+2 cycles, and is acknowledged with a gnt pulse on entry
//  and a done pulse (with read data) on completion.
//  Ports:
//    clk, reset            clock, synchronous active-high reset
//    reqN/addrN/weN/wdataN request, address, write enable, write data
//    gntN                  1-cycle pulse, request accepted
//    doneN                 1-cycle pulse, access complete
//    rdata                 registered read data, valid with doneN
//    mem_addr              registered memory address
//    mem_data_write        registered memory write data
//    mem_do_write          registered 1-cycle write strobe
//    mem_data_read         memory read data
//    busy                  access in flight
//  Configuration macro: MEM_ARB_ROUND_ROBIN_EN (see mem_arb_pick).
module mem_bus_arbiter
  import gb_mem_pkg::*;
#(
  parameter int READ_LATENCY = DEFAULT_READ_LATENCY,
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              we0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              we1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_write,
  output logic              mem_do_write,
  input  logic [DATA_W-1:0] mem_data_read,
  output logic              busy
);

  localparam int CNT_W = $clog2(READ_LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

  logic [1:0]       state;
  logic             owner;
  logic             owner_we;
  logic [CNT_W-1:0] cnt;
  logic             last_port;
  logic             pick_valid;
  logic             pick_port;

  mem_arb_pick u_pick (
    .req0      (req0),
    .req1      (req1),
    .last_port (last_port),
    .valid     (pick_valid),
    .port      (pick_port)
  );

  assign busy = (state != ARB_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ARB_IDLE;
      owner          <= PORT_CPU;
      owner_we       <= 1'b0;
      cnt            <= '0;
      last_port      <= PORT_DMA;
      gnt0           <= 1'b0;
      gnt1           <= 1'b0;
      done0          <= 1'b0;
      done1          <= 1'b0;
      mem_do_write   <= 1'b0;
      mem_addr       <= '0;
      mem_data_write <= '0;
      rdata          <= '0;
    end else begin
      // Pulses default low; only the transitions below raise them.
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      mem_do_write <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            mem_addr       <= (pick_port == PORT_DMA) ? addr1  : addr0;
            mem_data_write <= (pick_port == PORT_DMA) ? wdata1 : wdata0;
            mem_do_write   <= (pick_port == PORT_DMA) ? we1    : we0;
            owner_we       <= (pick_port == PORT_DMA) ? we1    : we0;
            gnt0           <= (pick_port == PORT_CPU);
            gnt1           <= (pick_port == PORT_DMA);
            owner          <= pick_port;
            last_port      <= pick_port;
            cnt            <= CNT_LOAD;
            state          <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if (cnt == '0) begin
            // Writes leave the last read value in place.
            if (!owner_we) begin
              rdata <= mem_data_read;
            end
            done0 <= (owner == PORT_CPU);
            done1 <= (owner == PORT_DMA);
            state <= ARB_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ARB_RESP: begin
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, mem_do_write, busy;
  logic [7:0]  rdata, mem_data_write, mem_data_read;
  logic [15:0] mem_addr;

  logic        req0_3;
  logic [15:0] addr0_3;
  logic        gnt0_3, gnt1_3, done0_3, done1_3, mem_do_write_3, busy_3;
  logic [7:0]  rdata_3, mem_data_write_3, mem_data_read_3;
  logic [15:0] mem_addr_3;

  logic [7:0]  mem [0:65535];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int gnt0_total = 0;
  int dual_gnt = 0;
  int dual_done = 0;
  int gnt_done = 0;

  mem_bus_arbiter #(.READ_LATENCY(1), .ADDR_W(16), .DATA_W(8)) u_dut (
    .clk            (clk),
    .reset          (reset),
    .req0           (req0),
    .addr0          (addr0),
    .we0            (we0),
    .wdata0         (wdata0),
    .req1           (req1),
    .addr1          (addr1),
    .we1            (we1),
    .wdata1         (wdata1),
    .gnt0           (gnt0),
    .gnt1           (gnt1),
    .done0          (done0),
    .done1          (done1),
    .rdata          (rdata),
    .mem_addr       (mem_addr),
    .mem_data_write (mem_data_write),
    .mem_do_write   (mem_do_write),
    .mem_data_read  (mem_data_read),
    .busy           (busy)
  );

  mem_bus_arbiter #(.READ_LATENCY(3), .ADDR_W(16), .DATA_W(8)) u_dut3 (
    .clk            (clk),
    .reset          (reset),
    .req0           (req0_3),
    .addr0          (addr0_3),
    .we0            (1'b0),
    .wdata0         (8'h00),
    .req1           (1'b0),
    .addr1          (16'h0000),
    .we1            (1'b0),
    .wdata1         (8'h00),
    .gnt0           (gnt0_3),
    .gnt1           (gnt1_3),
    .done0          (done0_3),
    .done1          (done1_3),
    .rdata          (rdata_3),
    .mem_addr       (mem_addr_3),
    .mem_data_write (mem_data_write_3),
    .mem_do_write   (mem_do_write_3),
    .mem_data_read  (mem_data_read_3),
    .busy           (busy_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_data_read   = mem[mem_addr];
  assign mem_data_read_3 = mem[mem_addr_3];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (mem_do_write) mem[mem_addr] = mem_data_write;
  end

  always @(negedge clk) begin
    if (gnt0) gnt0_total = gnt0_total + 1;
    if (gnt0 && gnt1) dual_gnt = dual_gnt + 1;
    if (done0 && done1) dual_done = dual_done + 1;
    if ((gnt0 || gnt1) && (done0 || done1)) gnt_done = gnt_done + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic exp_port;
    logic got_port;
    int   n;
    int   last_g;
    int   g0_before;

    reset = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    req0_3 = 0; addr0_3 = 0;
    mem[16'h0150] = 8'hC3;
    mem[16'hFE00] = 8'h00;
    mem[16'h1000] = 8'h11;
    mem[16'h2000] = 8'h22;
    mem[16'h0100] = 8'h00;
    mem[16'h0101] = 8'h7E;
    mem[16'h3000] = 8'h44;

    // Reset state
    tick(); tick();
    check("rst_gnt",   {gnt0, gnt1}, 0);
    check("rst_done",  {done0, done1}, 0);
    check("rst_wr",    mem_do_write, 0);
    check("rst_busy",  busy, 0);
    check("rst_addr",  mem_addr, 0);
    check("rst_wdata", mem_data_write, 0);
    check("rst_rdata", rdata, 0);
    reset = 1'b0;

    // 1: single cpu read
    req0 = 1; addr0 = 16'h0150; we0 = 0;
    tick();
    check("rd_gnt0", gnt0, 1);
    check("rd_gnt1", gnt1, 0);
    check("rd_addr", mem_addr, 16'h0150);
    check("rd_busy1", busy, 1);
    check("rd_nowr", mem_do_write, 0);
    req0 = 0;
    tick();
    check("rd_done0", done0, 1);
    check("rd_rdata", rdata, 8'hC3);
    check("rd_busy2", busy, 1);
    tick();
    check("rd_done_pulse", done0, 0);
    check("rd_idle", busy, 0);

    // 2: DMA write then cpu read-back
    req1 = 1; addr1 = 16'hFE00; we1 = 1; wdata1 = 8'h5A;
    tick();
    check("wr_gnt1", gnt1, 1);
    check("wr_strobe", mem_do_write, 1);
    check("wr_addr", mem_addr, 16'hFE00);
    check("wr_data", mem_data_write, 8'h5A);
    req1 = 0; we1 = 0;
    tick();
    check("wr_strobe_1cyc", mem_do_write, 0);
    check("wr_done1", done1, 1);
    check("wr_rdata_kept", rdata, 8'hC3);
    tick();
    req0 = 1; addr0 = 16'hFE00;
    tick();
    check("rb_gnt0", gnt0, 1);
    req0 = 0;
    tick();
    check("rb_done0", done0, 1);
    check("rb_rdata", rdata, 8'h5A);
    tick();

    // 3: contention, both held for four grants, starting from reset
    reset = 1; tick(); reset = 0;
    req0 = 1; addr0 = 16'h1000; we0 = 0;
    req1 = 1; addr1 = 16'h2000; we1 = 0;
    last_g = 0;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_port = (k % 2 == 1);
`else
      exp_port = 1'b1;
`endif
      n = 0;
      do begin
        tick();
        n++;
      end while (!(gnt0 || gnt1) && n < 10);
      check($sformatf("cont_gnt_seen%0d", k), gnt0 | gnt1, 1);
      got_port = gnt1;
      check($sformatf("cont_port%0d", k), got_port, exp_port);
      if (k > 0) check($sformatf("cont_space%0d", k), cyc - last_g, 3);
      last_g = cyc;
      tick();
      check($sformatf("cont_done%0d", k), exp_port ? done1 : done0, 1);
      check($sformatf("cont_rdata%0d", k), rdata, exp_port ? 8'h22 : 8'h11);
    end
    req0 = 0; req1 = 0;
    tick(); tick(); tick();
    check("cont_idle", busy, 0);

    // 4: READ_LATENCY=3, back-to-back spacing
    req0_3 = 1; addr0_3 = 16'h0100;
    tick();
    check("lat_gnt", gnt0_3, 1);
    check("lat_addr", mem_addr_3, 16'h0100);
    addr0_3 = 16'h0101;
    tick();
    check("lat_nodone2", done0_3, 0);
    tick();
    check("lat_nodone3", done0_3, 0);
    tick();
    check("lat_done4", done0_3, 1);
    check("lat_rdata", rdata_3, 8'h00);
    tick();
    check("lat_nognt5", gnt0_3, 0);
    tick();
    check("lat_gnt6", gnt0_3, 1);
    check("lat_addr6", mem_addr_3, 16'h0101);
    req0_3 = 0;
    tick(); tick();
    check("lat_nodone8", done0_3, 0);
    tick();
    check("lat_done9", done0_3, 1);
    check("lat_rdata2", rdata_3, 8'h7E);
    tick();

    // 5: reset during the ACCESS cycle of a write
    req1 = 1; addr1 = 16'h3000; we1 = 1; wdata1 = 8'h99;
    tick();
    check("mid_gnt1", gnt1, 1);
    check("mid_strobe", mem_do_write, 1);
    reset = 1; req1 = 0; we1 = 0;
    tick();
    check("mid_strobe_low", mem_do_write, 0);
    check("mid_busy", busy, 0);
    check("mid_done", done1, 0);
    check("mid_addr", mem_addr, 0);
    check("mid_wdata", mem_data_write, 0);
    check("mid_rdata", rdata, 0);
    reset = 0;
    tick();
    check("mid_no_late_done", done1, 0);

    // 6: cpu request withdrawn while DMA access in flight
    g0_before = gnt0_total;
    req1 = 1; addr1 = 16'h2000; we1 = 0;
    tick();
    check("wd_gnt1", gnt1, 1);
    req1 = 0; req0 = 1; addr0 = 16'h1000;
    tick();
    check("wd_done1", done1, 1);
    req0 = 0;
    for (int i = 0; i < 6; i++) tick();
    check("wd_no_gnt0", gnt0_total - g0_before, 0);

    check("no_dual_gnt", dual_gnt, 0);
    check("no_dual_done", dual_done, 0);
    check("no_gnt_done", gnt_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
